// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants, types and helpers for the MIPS instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned INSTR_W          = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {pc, data} entries with flush; reads return zero when empty.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [2*INSTR_W-1:0]         wdata,
    output logic [2*INSTR_W-1:0]         rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [2*INSTR_W-1:0] mem [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic                 do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign rdata  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && !do_pop && count == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited imem requests, buffers
// returned words in order and discards stale responses after a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [31:0]        inst_pc,
    output logic [31:0]        inst_pc_plus4
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    fetch_state_e         state;
    logic [31:0]          fetch_pc;
    logic [31:0]          rsp_pc;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        drop_cnt;
    logic [CW-1:0]        drop_next;
    logic [CW-1:0]        occupancy;
    logic [CW:0]          in_use;
    logic                 req_fire;
    logic                 rsp_drop;
    logic                 rsp_push;
    logic                 fifo_empty;
    logic [2*INSTR_W-1:0] head;

    assign in_use         = {1'b0, occupancy} + {1'b0, outstanding};
    assign imem_req_valid = rst && !redirect_valid && (in_use < CAP);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (redirect_valid || state == DRAIN);
    assign rsp_push       = imem_rsp_valid && !rsp_drop;

    // outstanding already counts earlier stale requests, so on a redirect it
    // alone (minus this cycle's response) is the accumulated drop count.
    always_comb begin
        drop_next = drop_cnt;
        if (redirect_valid) drop_next = outstanding - CW'(imem_rsp_valid);
        else if (rsp_drop)  drop_next = drop_cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? DRAIN : FETCH;
            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
                rsp_pc   <= align_pc(redirect_pc);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_INCR;
                if (rsp_push) rsp_pc <= rsp_pc + PC_INCR;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .pop   (inst_ready),
        .flush (redirect_valid),
        .wdata ({rsp_pc, imem_rsp_data}),
        .rdata (head),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign inst_valid    = !fifo_empty;
    assign inst_pc       = head[2*INSTR_W-1:INSTR_W];
    assign inst_data     = head[INSTR_W-1:0];
    assign inst_pc_plus4 = fifo_empty ? '0 : inst_pc + PC_INCR;

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (outstanding != '0));
    a_credit: assert property (@(posedge clk) disable iff (!rst)
        in_use <= CAP);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with directed corner scenarios.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    instr_fetch_unit #(
        .RESET_PC(RST_PC),
        .DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned pop_count = 0;
    int unsigned acc_count = 0;

    // stimulus knobs
    int unsigned ready_pct = 100, iready_pct = 100, redir_permille = 0;
    int unsigned lat_min = 1, lat_max = 1;
    logic        hold_rsp = 1'b0;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;

    // memory model and scoreboard
    int unsigned pend_due[$];
    logic [31:0] pend_data[$];
    logic [63:0] exp_q[$];
    logic [31:0] model_pc = RST_PC;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    // per-step samples
    logic        s_req_valid, s_inst_valid, s_rsp_valid;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        int unsigned lat;
        @(negedge clk);
        cyc++;
        if (!hold_rsp && pend_due.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_data.pop_front();
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < ready_pct);
        inst_ready     = ($urandom_range(99) < iready_pct);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_target;
            force_redir    = 1'b0;
        end else if ($urandom_range(999) < redir_permille) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : $urandom;
        end else begin
            redirect_valid = 1'b0;
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_rsp_valid  = imem_rsp_valid;
        if (prev_wait && !redirect_valid) begin
            check("req_hold_valid", 32'(imem_req_valid), 32'd1);
            check("req_hold_addr", imem_req_addr, prev_addr);
        end
        prev_wait = imem_req_valid && !imem_req_ready;
        prev_addr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, model_pc);
            lat = $urandom_range(lat_max, lat_min);
            pend_due.push_back(cyc + lat);
            pend_data.push_back(memf(imem_req_addr));
            exp_q.push_back({model_pc, memf(model_pc)});
            model_pc += 32'd4;
            acc_count++;
        end
        #1;
        if (redirect_valid) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic hold_and_release();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        pend_due.delete();
        pend_data.delete();
        exp_q.delete();
        model_pc  = RST_PC;
        prev_wait = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acc_count = 0;
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst_data"}, inst_data, 32'd0);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_inst_pc_plus4"}, inst_pc_plus4, 32'd0);
        hold_and_release();
        #1;
        check({tag, "_first_req_valid"}, 32'(imem_req_valid), 32'd1);
        check({tag, "_first_req_addr"}, imem_req_addr, RST_PC);
    endtask

    // scoreboard monitor: pops whenever decode consumes an instruction
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (inst_valid) begin
                    if (inst_ready) begin
                        pop_count++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_unexpected: got pc %h with no expected entry", inst_pc);
                        end else begin
                            e = exp_q.pop_front();
                            check("inst_pc", inst_pc, e[63:32]);
                            check("inst_data", inst_data, e[31:0]);
                            check("inst_pc_plus4", inst_pc_plus4, e[63:32] + 32'd4);
                        end
                    end
                end else begin
                    check("empty_inst_data", inst_data, NOP_WORD);
                    check("empty_inst_pc", inst_pc, 32'd0);
                end
            end
        end
    end

    initial begin
        int unsigned p0;
        logic [5:0] vseq;

        // reset state
        #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_pc_plus4", inst_pc_plus4, 32'd0);
        hold_and_release();

        // streaming at full rate
        ready_pct = 100; iready_pct = 100; lat_min = 1; lat_max = 1;
        vseq = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            vseq[i] = s_inst_valid;
            if (i == 3) check("stream_acc4", acc_count, 32'd4);
        end
        check("stream_valid_seq", 32'(vseq), 32'b111100);
        p0 = pop_count;
        repeat (16) step();
        check("stream_no_bubbles", pop_count - p0, 32'd16);

        // decode backpressure caps requests at DEPTH
        hold_and_release();
        iready_pct = 0;
        repeat (10) step();
        check("bp_requests", acc_count, 32'd4);
        check("bp_req_valid_low", 32'(s_req_valid), 32'd0);
        iready_pct = 100;
        repeat (20) step();

        // redirect with 2 in flight and 2 buffered
        hold_and_release();
        iready_pct = 0; hold_rsp = 1'b1;
        repeat (4) step();
        hold_rsp = 1'b0; ready_pct = 0;
        repeat (2) step();
        check("rd_fifo_filled", 32'(s_inst_valid), 32'd1);
        hold_rsp = 1'b1; force_redir = 1'b1; force_target = 32'h40;
        step();
        hold_rsp = 1'b0; ready_pct = 100; iready_pct = 100;
        step();
        check("rd_flushed", 32'(s_inst_valid), 32'd0);
        step();
        check("rd_stale_dropped", 32'(s_inst_valid), 32'd0);
        repeat (10) step();
        check("rd_fsm_fetch", 32'(dut.state), 32'(FETCH));

        // redirect coinciding with response and pop, misaligned target
        repeat (4) step();
        force_redir = 1'b1; force_target = 32'h103;
        step();
        check("co_rsp_present", 32'(s_rsp_valid), 32'd1);
        check("co_pop_present", 32'(s_inst_valid && inst_ready), 32'd1);
        step();
        check("co_next_addr", s_req_addr, 32'h100);
        repeat (8) step();

        // address wrap with ready toggling
        force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
        step();
        ready_pct = 100; step();
        ready_pct = 0;   step();
        check("wrap_hold_valid", 32'(s_req_valid), 32'd1);
        check("wrap_addr", s_req_addr, 32'h0);
        ready_pct = 100; step();
        repeat (8) step();

        // async reset with a full FIFO
        hold_and_release();
        iready_pct = 0;
        repeat (8) step();
        check("full_inst_valid", 32'(s_inst_valid), 32'd1);
        async_reset_check("rst_full");

        // async reset during DRAIN
        iready_pct = 0; hold_rsp = 1'b1;
        repeat (4) step();
        force_redir = 1'b1; force_target = 32'h200;
        step();
        step();
        check("drain_state", 32'(dut.state), 32'(DRAIN));
        hold_rsp = 1'b0;
        async_reset_check("rst_drain");

        // randomized traffic
        hold_and_release();
        ready_pct = 70; iready_pct = 70; lat_min = 1; lat_max = 4; redir_permille = 20;
        p0 = pop_count;
        repeat (3000) step();
        redir_permille = 0; ready_pct = 0; iready_pct = 100;
        repeat (30) step();
        check("rand_progress", 32'(pop_count - p0 >= 200), 32'd1);
        check("rand_sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
